// File: rtl/serial_uart_bridge.sv
// Purpose: byte-serial port responder; TX FIFO -> 8N1 UART out, UART in -> RX FIFO with valid/rden.
// Latency: byte written at edge N pops at N+1 (line falls then); RX byte visible 1 cycle after stop-bit centre.
// Backpressure: ready_out=0 when TX FIFO full (writes dropped, tx_overflow); RX bytes dropped when RX FIFO full.
//
// Ports:
//   clk, reset            clock (rising edge), asynchronous active-low reset
//   wr_data_in/wren_in    processor write byte/strobe into TX FIFO; ready_out = TX FIFO not full
//   rden_in/rd_data_out   RX FIFO pop strobe / show-ahead head byte; valid_out = RX FIFO not empty
//   uart_rx_in/uart_tx_out serial pins, idle high (tx registered)
//   status_out            sticky {framing_err, rx_overflow, tx_overflow}; status_clr_in clears

// Purpose: small circular FIFO, pointers carry an extra wrap bit.
// Latency: push visible at head the cycle after the push edge.
// Backpressure: push ignored when full, pop ignored when empty.
module bridge_fifo #(
    parameter int W  = 8,
    parameter int AW = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int DEPTH = 1 << AW;

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         do_push;
    logic         do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end
endmodule

module serial_uart_bridge #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_AW      = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] wr_data_in,
    input  logic       wren_in,
    output logic       ready_out,
    input  logic       rden_in,
    output logic [7:0] rd_data_out,
    output logic       valid_out,
    input  logic       uart_rx_in,
    output logic       uart_tx_out,
    output logic [2:0] status_out,
    input  logic       status_clr_in
);
    localparam int             CW        = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]  BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]  HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} uart_st_t;

    // ---------------- FIFOs ----------------
    logic       tx_full, tx_empty, tx_pop;
    logic [7:0] tx_fifo_dat;
    logic       rx_full, rx_empty, rx_push;
    logic [7:0] rx_head_dat;
    logic [7:0] rx_shift;
    logic [7:0] rd_hold_q;

    bridge_fifo #(.W(8), .AW(FIFO_AW)) u_tx_fifo (
        .clk(clk), .reset(reset),
        .push(wren_in), .din(wr_data_in),
        .pop(tx_pop), .dout(tx_fifo_dat),
        .full(tx_full), .empty(tx_empty)
    );

    bridge_fifo #(.W(8), .AW(FIFO_AW)) u_rx_fifo (
        .clk(clk), .reset(reset),
        .push(rx_push), .din(rx_shift),
        .pop(rden_in), .dout(rx_head_dat),
        .full(rx_full), .empty(rx_empty)
    );

    assign ready_out = !tx_full;
    assign valid_out = !rx_empty;

    // Head byte while non-empty; otherwise the last head seen, so the bus holds steady.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)         rd_hold_q <= 8'h00;
        else if (!rx_empty) rd_hold_q <= rx_head_dat;
    end
    assign rd_data_out = rx_empty ? rd_hold_q : rx_head_dat;

    // ---------------- TX FSM ----------------
    uart_st_t      tx_st, tx_st_nxt;
    logic [CW-1:0] tx_cnt, tx_cnt_nxt;
    logic [2:0]    tx_bit, tx_bit_nxt;
    logic [7:0]    tx_shift, tx_shift_nxt;
    logic          tx_line_q, tx_line_nxt;
    logic          tx_done;

    assign tx_done = (tx_cnt == BIT_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_st     <= ST_IDLE;
            tx_cnt    <= '0;
            tx_bit    <= '0;
            tx_shift  <= '0;
            tx_line_q <= 1'b1;
        end else begin
            tx_st     <= tx_st_nxt;
            tx_cnt    <= tx_cnt_nxt;
            tx_bit    <= tx_bit_nxt;
            tx_shift  <= tx_shift_nxt;
            tx_line_q <= tx_line_nxt;
        end
    end

    always_comb begin
        tx_st_nxt    = tx_st;
        tx_cnt_nxt   = tx_cnt + 1'b1;
        tx_bit_nxt   = tx_bit;
        tx_shift_nxt = tx_shift;
        case (tx_st)
            ST_IDLE: begin
                tx_cnt_nxt = '0;
                if (!tx_empty) begin
                    tx_st_nxt    = ST_START;
                    tx_shift_nxt = tx_fifo_dat;
                end
            end
            ST_START: begin
                if (tx_done) begin
                    tx_st_nxt  = ST_DATA;
                    tx_cnt_nxt = '0;
                    tx_bit_nxt = '0;
                end
            end
            ST_DATA: begin
                if (tx_done) begin
                    tx_cnt_nxt   = '0;
                    tx_shift_nxt = {1'b0, tx_shift[7:1]};
                    tx_bit_nxt   = tx_bit + 1'b1;
                    if (tx_bit == 3'd7) tx_st_nxt = ST_STOP;
                end
            end
            default: begin // ST_STOP: chain straight into the next frame if one is waiting
                if (tx_done) begin
                    tx_cnt_nxt = '0;
                    if (!tx_empty) begin
                        tx_st_nxt    = ST_START;
                        tx_shift_nxt = tx_fifo_dat;
                    end else begin
                        tx_st_nxt = ST_IDLE;
                    end
                end
            end
        endcase
    end

    // Line level is computed from the next state so the registered pin changes on the same edge.
    always_comb begin
        tx_pop      = ((tx_st == ST_IDLE) || ((tx_st == ST_STOP) && tx_done)) && !tx_empty;
        tx_line_nxt = 1'b1;
        case (tx_st_nxt)
            ST_START: tx_line_nxt = 1'b0;
            ST_DATA:  tx_line_nxt = tx_shift_nxt[0];
            default:  tx_line_nxt = 1'b1;
        endcase
    end

    assign uart_tx_out = tx_line_q;

    // ---------------- RX path ----------------
    logic [1:0]    rx_sync;
    logic          rx_s;
    uart_st_t      rx_st, rx_st_nxt;
    logic [CW-1:0] rx_cnt, rx_cnt_nxt;
    logic [2:0]    rx_bit, rx_bit_nxt;
    logic [7:0]    rx_shift_nxt;
    logic          rx_done;
    logic          rx_stop_smp;
    logic          rx_ovf_set;
    logic          ferr_set;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rx_sync <= 2'b11;
        else        rx_sync <= {rx_sync[0], uart_rx_in};
    end
    assign rx_s    = rx_sync[1];
    assign rx_done = (rx_cnt == BIT_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_st    <= ST_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
        end else begin
            rx_st    <= rx_st_nxt;
            rx_cnt   <= rx_cnt_nxt;
            rx_bit   <= rx_bit_nxt;
            rx_shift <= rx_shift_nxt;
        end
    end

    always_comb begin
        rx_st_nxt    = rx_st;
        rx_cnt_nxt   = rx_cnt + 1'b1;
        rx_bit_nxt   = rx_bit;
        rx_shift_nxt = rx_shift;
        case (rx_st)
            ST_IDLE: begin
                rx_cnt_nxt = '0;
                if (!rx_s) rx_st_nxt = ST_START;
            end
            ST_START: begin
                // Half a bit in: still low means a real start bit, aligned to bit centres.
                if (rx_cnt == HALF_LAST) begin
                    rx_cnt_nxt = '0;
                    rx_bit_nxt = '0;
                    rx_st_nxt  = rx_s ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (rx_done) begin
                    rx_cnt_nxt   = '0;
                    rx_shift_nxt = {rx_s, rx_shift[7:1]};
                    rx_bit_nxt   = rx_bit + 1'b1;
                    if (rx_bit == 3'd7) rx_st_nxt = ST_STOP;
                end
            end
            default: begin // ST_STOP: leave at mid stop bit to be ready for the next start edge
                if (rx_done) rx_st_nxt = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        rx_stop_smp = (rx_st == ST_STOP) && rx_done;
        rx_push     = rx_stop_smp && rx_s && !rx_full;
        rx_ovf_set  = rx_stop_smp && rx_s && rx_full;
        ferr_set    = rx_stop_smp && !rx_s;
    end

    // ---------------- Status ----------------
    logic [2:0] status_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) status_q <= 3'b000;
        else        status_q <= (status_q & {3{~status_clr_in}})
                              | {ferr_set, rx_ovf_set, wren_in && tx_full};
    end
    assign status_out = status_q;
endmodule
